display_scanner: RTL

Time-multiplexed driver for the board's multi-digit 7-segment display. It latches a 32-bit value from the datapath, selects one hex nibble per time slot, and presents it to the downstream 4-bit-to-7-segment decoder together with the matching active-low digit-enable. The digit enables rotate at a rate slow enough to be flicker-free. Sits between the CPU debug/register-view mux (upstream) and the 7-segment decoder (downstream).

---
 rtl/display_scanner.sv | 73 +++++++
 1 files changed

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner: latches a 32-bit word, holds each hex digit for PRESCALE cycles.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module display_scanner #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       value,
    input  logic              load,
    output logic [3:0]        nibble,
    output logic [DIGITS-1:0] anode_n,
    output logic              frame_tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PC_LAST  = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     pc, pc_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [31:0]       shadow, disp, disp_nxt;
    logic              pc_last, wrap;
    logic [3:0]        nibble_nxt;
    logic [DIGITS-1:0] anode_nxt;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [31:0] VMASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << (4 * DIGITS)) - 32'd1);
    logic [31:0] upper;
    logic        blank;
`endif

    always_comb begin
        pc_last  = (pc == PC_LAST);
        wrap     = pc_last && (idx == IDX_LAST);
        pc_nxt   = pc_last ? '0 : pc + PW'(1);
        idx_nxt  = idx;
        if (pc_last)
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        // disp only changes at the frame boundary so a frame never mixes two words
        disp_nxt   = wrap ? shadow : disp;
        nibble_nxt = 4'(disp_nxt >> {idx_nxt, 2'b00});
        anode_nxt  = ~(DIGITS'(1) << idx_nxt);
`ifdef LEADING_ZERO_BLANK_EN
        upper = (disp_nxt >> {idx_nxt, 2'b00}) & VMASK;
        blank = (idx_nxt != '0) && (upper == '0);
        if (blank)
            anode_nxt = '1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= '0;
            idx        <= '0;
            shadow     <= '0;
            disp       <= '0;
            nibble     <= 4'h0;
            anode_n    <= ~(DIGITS'(1));
            frame_tick <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            idx        <= idx_nxt;
            disp       <= disp_nxt;
            if (load)
                shadow <= value;
            nibble     <= nibble_nxt;
            anode_n    <= anode_nxt;
            frame_tick <= wrap;
        end
    end
endmodule
